// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer rectangle writer.
// Holds the visible-area limits, the framebuffer geometry, the
// half-resolution selection rule and the writer FSM state type.
package fb_pkg;

  localparam int MAX_SX    = 799;   // last visible column
  localparam int MAX_SY    = 479;   // last visible row
  localparam int LINE_W    = 800;   // pixels per framebuffer row
  localparam int FB_ADDR_W = 19;    // framebuffer word address width
  localparam int PIX_W     = 4;     // palette index width
  localparam int COORD_W   = 10;    // coordinate / size width

  // Full 800x480 frame in pixels; smaller buffers store two pixels per word.
  localparam int FULL_FB_SIZE   = LINE_W * (MAX_SY + 1);
  localparam int HALF_RES_LIMIT = 192000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLIP = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } fb_state_t;

  // Half-resolution addressing is used whenever the buffer cannot hold a full frame.
  function automatic bit half_res_of(input int fb_size);
    bit r_half;
    if (fb_size > HALF_RES_LIMIT) begin
      r_half = 1'b0;
    end else begin
      r_half = 1'b1;
    end
    return r_half;
  endfunction

  // Linear pixel index to framebuffer word address, same mapping as scan-out.
  function automatic logic [FB_ADDR_W-1:0] fb_map(input logic [FB_ADDR_W-1:0] lin,
                                                  input bit half_res);
    logic [FB_ADDR_W-1:0] addr;
    if (half_res) begin
      addr = lin >> 1;
    end else begin
      addr = lin;
    end
    return addr;
  endfunction

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational rectangle clipper.
// Clips a rectangle to the visible area and produces the linear index of
// its top-left pixel.
//   i_x0, i_y0 : rectangle origin
//   i_w, i_h   : rectangle size in pixels
//   o_x1, o_y1 : last column / row inside the visible area
//   o_row_base : y0*LINE_W + x0 (valid only when o_empty is 0)
//   o_empty    : rectangle has no visible pixels
module fb_rect_clip
  import fb_pkg::*;
(
  input  logic [COORD_W-1:0]   i_x0,
  input  logic [COORD_W-1:0]   i_y0,
  input  logic [COORD_W-1:0]   i_w,
  input  logic [COORD_W-1:0]   i_h,
  output logic [COORD_W-1:0]   o_x1,
  output logic [COORD_W-1:0]   o_y1,
  output logic [FB_ADDR_W-1:0] o_row_base,
  output logic                 o_empty
);

  // 11-bit end coordinates so x0+w-1 cannot wrap.
  logic [COORD_W:0] w_x_end;
  logic [COORD_W:0] w_y_end;

  // Clip the far corner, flag empty rectangles and form the first row base.
  always_comb begin
    w_x_end = {1'b0, i_x0} + {1'b0, i_w} - 11'd1;
    w_y_end = {1'b0, i_y0} + {1'b0, i_h} - 11'd1;

    if (w_x_end > 11'(MAX_SX)) begin
      o_x1 = 10'(MAX_SX);
    end else begin
      o_x1 = w_x_end[COORD_W-1:0];
    end

    if (w_y_end > 11'(MAX_SY)) begin
      o_y1 = 10'(MAX_SY);
    end else begin
      o_y1 = w_y_end[COORD_W-1:0];
    end

    // A zero size wraps w_x_end/w_y_end, but the empty flag masks that case.
    o_empty = (i_w == 10'd0) || (i_h == 10'd0) ||
              (i_x0 > 10'(MAX_SX)) || (i_y0 > 10'(MAX_SY));

    // The only multiply in the block; it is used once per command.
    o_row_base = FB_ADDR_W'(i_y0) * FB_ADDR_W'(LINE_W) + FB_ADDR_W'(i_x0);
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Framebuffer rectangle writer: fills clipped rectangles with one palette
// index, one pixel per cycle, into the framebuffer RAM write port.
//   clk, rst          : clock, synchronous active-high reset
//   cmd_valid/ready   : command handshake
//   cmd_x0/y0/w/h     : rectangle origin and size
//   cmd_color         : palette index to write
//   wr_stall          : framebuffer port unavailable
//   wr_en/addr/data   : registered framebuffer write port
//   busy              : command in progress
//   done              : one-cycle pulse when a command completes
// All outputs are registered. A write is launched at a clock edge where
// wr_stall is low; a launched pixel appears on the port the following cycle.
// The first pixel is launched at the end of the CLIP cycle, so it appears two
// cycles after accept. Each stalled launch edge delays the rest of the fill by
// one cycle. FILL lasts one more cycle after the last launch, while the last
// write is on the port. done follows in the cycle after that.
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter int FRAMEBUFFER_SIZE = FULL_FB_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [COORD_W-1:0]   cmd_x0,
  input  logic [COORD_W-1:0]   cmd_y0,
  input  logic [COORD_W-1:0]   cmd_w,
  input  logic [COORD_W-1:0]   cmd_h,
  input  logic [PIX_W-1:0]     cmd_color,
  input  logic                 wr_stall,
  output logic                 wr_en,
  output logic [FB_ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]     wr_data,
  output logic                 busy,
  output logic                 done
);

  localparam bit HALF_RES = half_res_of(FRAMEBUFFER_SIZE);
  localparam logic [FB_ADDR_W-1:0] LINE_STRIDE = FB_ADDR_W'(LINE_W);

  fb_state_t r_state;

  // Latched command
  logic [COORD_W-1:0]   r_x0, r_y0, r_w, r_h;
  logic [PIX_W-1:0]     r_color;

  // Fill walker: next pixel to launch, clip limits, row start and linear index
  logic [COORD_W-1:0]   r_x, r_y, r_x1, r_y1;
  logic [FB_ADDR_W-1:0] r_row_base, r_lin;
  logic                 r_all_sent;

  // Registered outputs
  logic                 r_cmd_ready, r_wr_en, r_busy, r_done;
  logic [FB_ADDR_W-1:0] r_wr_addr;
  logic [PIX_W-1:0]     r_wr_data;

  // Clipper results, valid during CLIP
  logic [COORD_W-1:0]   w_clip_x1, w_clip_y1;
  logic [FB_ADDR_W-1:0] w_clip_row_base;
  logic                 w_clip_empty;

  // Pixel that would be launched at the coming edge, and the walker state after it
  logic [COORD_W-1:0]   w_cur_x, w_cur_y, w_cur_x1, w_cur_y1;
  logic [FB_ADDR_W-1:0] w_cur_base, w_cur_lin;
  logic [COORD_W-1:0]   w_nxt_x, w_nxt_y;
  logic [FB_ADDR_W-1:0] w_nxt_base, w_nxt_lin;
  logic                 w_row_end, w_last, w_can_issue, w_issue;

  fb_rect_clip u_clip (
    .i_x0       (r_x0),
    .i_y0       (r_y0),
    .i_w        (r_w),
    .i_h        (r_h),
    .o_x1       (w_clip_x1),
    .o_y1       (w_clip_y1),
    .o_row_base (w_clip_row_base),
    .o_empty    (w_clip_empty)
  );

  // Select the pixel to launch: CLIP feeds the freshly clipped origin, FILL the walker.
  always_comb begin
    w_cur_x    = r_x;
    w_cur_y    = r_y;
    w_cur_x1   = r_x1;
    w_cur_y1   = r_y1;
    w_cur_base = r_row_base;
    w_cur_lin  = r_lin;
    if (r_state == CLIP) begin
      w_cur_x    = r_x0;
      w_cur_y    = r_y0;
      w_cur_x1   = w_clip_x1;
      w_cur_y1   = w_clip_y1;
      w_cur_base = w_clip_row_base;
      w_cur_lin  = w_clip_row_base;
    end else begin
      w_cur_x    = r_x;
      w_cur_y    = r_y;
      w_cur_x1   = r_x1;
      w_cur_y1   = r_y1;
      w_cur_base = r_row_base;
      w_cur_lin  = r_lin;
    end
  end

  // Advance the walker: step right, or wrap to x0 and add one row stride.
  always_comb begin
    w_row_end = (w_cur_x == w_cur_x1);
    w_last    = w_row_end && (w_cur_y == w_cur_y1);
    if (w_row_end) begin
      w_nxt_x    = r_x0;
      w_nxt_y    = w_cur_y + 10'd1;
      w_nxt_base = w_cur_base + LINE_STRIDE;
      w_nxt_lin  = w_cur_base + LINE_STRIDE;
    end else begin
      w_nxt_x    = w_cur_x + 10'd1;
      w_nxt_y    = w_cur_y;
      w_nxt_base = w_cur_base;
      w_nxt_lin  = w_cur_lin + 19'd1;
    end
    w_can_issue = ((r_state == CLIP) && !w_clip_empty) ||
                  ((r_state == FILL) && !r_all_sent);
    w_issue     = w_can_issue && !wr_stall;
  end

  // Writer FSM, walker registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_x0        <= 10'd0;
      r_y0        <= 10'd0;
      r_w         <= 10'd0;
      r_h         <= 10'd0;
      r_color     <= 4'd0;
      r_x         <= 10'd0;
      r_y         <= 10'd0;
      r_x1        <= 10'd0;
      r_y1        <= 10'd0;
      r_row_base  <= 19'd0;
      r_lin       <= 19'd0;
      r_all_sent  <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= 19'd0;
      r_wr_data   <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;

      if (w_issue) begin
        r_wr_en    <= 1'b1;
        r_wr_addr  <= fb_map(w_cur_lin, HALF_RES);
        r_wr_data  <= r_color;
        r_x        <= w_nxt_x;
        r_y        <= w_nxt_y;
        r_row_base <= w_nxt_base;
        r_lin      <= w_nxt_lin;
        r_all_sent <= w_last;
      end else if (w_can_issue) begin
        // Stalled: hold position (and load the clipped origin if still in CLIP).
        r_x        <= w_cur_x;
        r_y        <= w_cur_y;
        r_row_base <= w_cur_base;
        r_lin      <= w_cur_lin;
        r_all_sent <= 1'b0;
      end else begin
        r_x        <= r_x;
        r_y        <= r_y;
        r_row_base <= r_row_base;
        r_lin      <= r_lin;
        r_all_sent <= r_all_sent;
      end

      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (cmd_valid && r_cmd_ready) begin
            r_x0        <= cmd_x0;
            r_y0        <= cmd_y0;
            r_w         <= cmd_w;
            r_h         <= cmd_h;
            r_color     <= cmd_color;
            r_all_sent  <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= CLIP;
          end else begin
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        CLIP: begin
          r_x1 <= w_clip_x1;
          r_y1 <= w_clip_y1;
          if (w_clip_empty) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= FILL;
          end
        end
        FILL: begin
          // Once the last pixel is on the port, finish with the done pulse.
          if (r_all_sent) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= FILL;
          end
        end
        DONE: begin
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: a full-resolution and a half-resolution instance
// share stimulus. Expected pixels come from a nested-loop walk of the clipped
// rectangle; timing comes from a count of pending pixels and stalled launches.
module tb_fb_rect_writer;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, wr_stall;
  logic [9:0]  cmd_x0, cmd_y0, cmd_w, cmd_h;
  logic [3:0]  cmd_color;

  logic        f_ready, f_wr_en, f_busy, f_done;
  logic [18:0] f_addr;
  logic [3:0]  f_data;
  logic        h_ready, h_wr_en, h_busy, h_done;
  logic [18:0] h_addr;
  logic [3:0]  h_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_rect_writer #(.FRAMEBUFFER_SIZE(384000)) u_full (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(f_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .wr_stall(wr_stall), .wr_en(f_wr_en),
    .wr_addr(f_addr), .wr_data(f_data), .busy(f_busy), .done(f_done)
  );

  fb_rect_writer #(.FRAMEBUFFER_SIZE(192000)) u_half (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(h_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .wr_stall(wr_stall), .wr_en(h_wr_en),
    .wr_addr(h_addr), .wr_data(h_data), .busy(h_busy), .done(h_done)
  );

  typedef struct {
    int x0, y0, w, h, color;
    int rnd;                 // 1: random stall, 0: stall window below
    int stall_lo, stall_hi;  // stall on cycles [lo,hi] after accept
    int exp_n;               // expected writes, -1 = not tabulated
    int exp_first, exp_last; // expected full-res first/last address
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int q[$];
    int xe, ye, p, pending, stalls, done_f, done_h, nd_f, nd_h, n_wr, n_wr_h, first_a, last_a, a;
    bit exp_wen, st, finished;
    xe = v.x0 + v.w - 1; if (xe > 799) xe = 799;
    ye = v.y0 + v.h - 1; if (ye > 479) ye = 479;
    if (v.w > 0 && v.h > 0 && v.x0 <= 799 && v.y0 <= 479)
      for (int yy = v.y0; yy <= ye; yy++)
        for (int xx = v.x0; xx <= xe; xx++)
          q.push_back(yy * 800 + xx);
    p = q.size();
    for (int i = 0; i < 20 && !f_ready; i++) @(negedge clk);
    chk("ready_before_cmd", int'(f_ready), 1);
    chk("ready_before_cmd_h", int'(h_ready), 1);
    cmd_x0 = 10'(v.x0); cmd_y0 = 10'(v.y0); cmd_w = 10'(v.w); cmd_h = 10'(v.h);
    cmd_color = 4'(v.color); cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    pending = p; stalls = 0; exp_wen = 1'b0; finished = 1'b0;
    done_f = -1; done_h = -1; nd_f = 0; nd_h = 0; n_wr = 0; n_wr_h = 0;
    first_a = -1; last_a = -1;
    for (int off = 1; off <= 4 * p + 64 && !finished; off++) begin
      if (done_f >= 0 && off == done_f + 1) begin
        chk("ready_after_done", int'(f_ready), 1);
        chk("busy_after_done", int'(f_busy), 0);
        chk("ready_after_done_h", int'(h_ready), 1);
        chk("busy_after_done_h", int'(h_busy), 0);
        chk("done_width", int'(f_done), 0);
        finished = 1'b1;
      end else begin
        chk("busy", int'(f_busy), 1);
        chk("ready_busy", int'(f_ready), 0);
        chk("wr_en", int'(f_wr_en), int'(exp_wen));
        chk("wr_en_h", int'(h_wr_en), int'(exp_wen));
        if (h_wr_en) n_wr_h++;
        if (f_wr_en) begin
          n_wr++;
          if (q.size() > 0) begin
            a = q.pop_front();
            chk("addr", int'(f_addr), a);
            chk("addr_half", int'(h_addr), a >> 1);
            chk("data", int'(f_data), v.color);
            chk("data_half", int'(h_data), v.color);
            if (n_wr == 1) first_a = int'(f_addr);
            last_a = int'(f_addr);
          end else begin
            chk("extra_write", n_wr, p);
          end
        end
        if (f_done) begin nd_f++; if (done_f < 0) done_f = off; end
        if (h_done) begin nd_h++; if (done_h < 0) done_h = off; end
        if (v.rnd != 0) st = ($urandom_range(0, 3) == 0);
        else st = (off >= v.stall_lo && off <= v.stall_hi);
        wr_stall = st;
        if (pending > 0) begin
          if (st) begin exp_wen = 1'b0; stalls++; end
          else begin exp_wen = 1'b1; pending--; end
        end else begin
          exp_wen = 1'b0;
        end
        @(posedge clk); @(negedge clk);
      end
    end
    wr_stall = 1'b0;
    chk("done_seen_in_budget", int'(finished), 1);
    chk("done_count", nd_f, 1);
    chk("done_count_h", nd_h, 1);
    chk("done_latency", done_f, 2 + p + stalls);
    chk("done_latency_h", done_h, 2 + p + stalls);
    chk("write_count", n_wr, p);
    chk("write_count_h", n_wr_h, p);
    if (v.exp_n >= 0) chk("table_write_count", n_wr, v.exp_n);
    if (v.exp_n > 0) begin
      chk("table_first_addr", first_a, v.exp_first);
      chk("table_last_addr", last_a, v.exp_last);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t rv;
    int nw, nd;
    rst = 1'b1; cmd_valid = 1'b0; wr_stall = 1'b0;
    cmd_x0 = 10'd0; cmd_y0 = 10'd0; cmd_w = 10'd0; cmd_h = 10'd0; cmd_color = 4'd0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_ready", int'(f_ready), 0);
    chk("rst_wr_en", int'(f_wr_en), 0);
    chk("rst_addr", int'(f_addr), 0);
    chk("rst_data", int'(f_data), 0);
    chk("rst_busy", int'(f_busy), 0);
    chk("rst_done", int'(f_done), 0);
    chk("rst_ready_h", int'(h_ready), 0);
    chk("rst_wr_en_h", int'(h_wr_en), 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("idle_ready", int'(f_ready), 1);
    chk("idle_busy", int'(f_busy), 0);

    tbl[0] = '{10, 20, 3, 2, 5, 0, 0, -1, 6, 16010, 16812};
    tbl[1] = '{798, 479, 10, 10, 3, 0, 0, -1, 2, 383998, 383999};
    tbl[2] = '{10, 10, 0, 5, 1, 0, 0, -1, 0, 0, 0};
    tbl[3] = '{900, 10, 5, 5, 2, 0, 0, -1, 0, 0, 0};
    tbl[4] = '{0, 0, 4, 1, 6, 0, 2, 4, 4, 0, 3};
    tbl[5] = '{1, 1, 3, 1, 12, 0, 0, -1, 3, 801, 803};
    tbl[6] = '{5, 480, 4, 4, 7, 0, 0, -1, 0, 0, 0};
    tbl[7] = '{799, 0, 1, 1, 15, 0, 0, -1, 1, 799, 799};
    tbl[8] = '{0, 479, 1, 1, 4, 0, 0, -1, 1, 383200, 383200};
    tbl[9] = '{796, 100, 4, 3, 8, 0, 1, 1, 12, 80796, 82399};
    for (int i = 0; i < 10; i++) run_cmd(tbl[i]);

    // Reset in the middle of a 100x100 fill
    for (int i = 0; i < 20 && !f_ready; i++) @(negedge clk);
    cmd_x0 = 10'd50; cmd_y0 = 10'd60; cmd_w = 10'd100; cmd_h = 10'd100;
    cmd_color = 4'd9; cmd_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    nw = 0; nd = 0;
    for (int i = 1; i <= 20; i++) begin
      if (f_wr_en) nw++;
      if (f_done) nd++;
      @(posedge clk); @(negedge clk);
    end
    chk("abort_writes_before_rst", nw, 19);
    chk("abort_no_done_before_rst", nd, 0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_wr_en", int'(f_wr_en), 0);
    chk("abort_busy", int'(f_busy), 0);
    chk("abort_done", int'(f_done), 0);
    chk("abort_ready_in_rst", int'(f_ready), 0);
    chk("abort_wr_en_h", int'(h_wr_en), 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort_ready_after", int'(f_ready), 1);
    chk("abort_wr_en_after", int'(f_wr_en), 0);
    chk("abort_done_after", int'(f_done), 0);
    chk("abort_busy_after", int'(f_busy), 0);
    run_cmd(tbl[0]);

    // Randomized commands, biased toward the right and bottom edges
    for (int i = 0; i < 40; i++) begin
      rv.x0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(780, 830)) : int'($urandom_range(0, 820));
      rv.y0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(460, 500)) : int'($urandom_range(0, 490));
      rv.w = int'($urandom_range(0, 24));
      rv.h = int'($urandom_range(0, 12));
      rv.color = int'($urandom_range(0, 15));
      rv.rnd = 1; rv.stall_lo = 0; rv.stall_hi = -1;
      rv.exp_n = -1; rv.exp_first = 0; rv.exp_last = 0;
      run_cmd(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_rect_writer.md
Name: fb_rect_writer

Overview:
Framebuffer writer: the producer side of the 4-bit palette-index framebuffer that the VGA scan-out reads.
- Accepts rectangle-fill commands (origin, size, palette index) over a valid/ready handshake.
- Clips each rectangle to the 800x480 visible area.
- Writes one pixel per cycle into the framebuffer RAM write port, using the same address mapping as scan-out.
- Sits between the game/draw logic and the framebuffer BRAM.

Parameters:
MAX_SX, 799, last visible column
MAX_SY, 479, last visible row
LINE_W, 800, pixels per framebuffer row (address stride)
HALF_RES, 0 if FRAMEBUFFER_SIZE > 192000 else 1, when 1 the write address is (y*LINE_W+x)>>1 (a35t build)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_x0  in  10  rectangle left column
cmd_y0  in  10  rectangle top row
cmd_w  in  10  width in pixels
cmd_h  in  10  height in pixels
cmd_color  in  4  palette index to write
wr_stall  in  1  framebuffer port unavailable this cycle
wr_en  out  1  write strobe
wr_addr  out  19  framebuffer word address
wr_data  out  4  palette index
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset values: cmd_ready=0 during the reset cycle, then 1 in IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0; FSM to IDLE. Reset mid-fill aborts the fill immediately with no further writes and no done pulse.
- States:
  - IDLE: cmd_ready=1. A command is accepted when cmd_valid and cmd_ready are both 1. On accept, latch all cmd_* fields and go to CLIP.
  - CLIP (1 cycle): compute x1=min(x0+w-1, MAX_SX) and y1=min(y0+h-1, MAX_SY) using 11-bit sums so no overflow. Compute row_base=y0*LINE_W+x0. If w==0, h==0, x0>MAX_SX or y0>MAX_SY, go to DONE with zero writes; otherwise go to FILL with x=x0, y=y0.
  - FILL: each cycle with wr_stall=0:
    - Drive wr_en=1, wr_addr=map(row_base+(x-x0)), wr_data=color.
    - Advance x. When x==x1: x returns to x0, y increments, row_base += LINE_W.
    - After writing (x1,y1), go to DONE.
    - With wr_stall=1: wr_en=0 and all counters hold.
  - DONE (1 cycle): done=1, then IDLE.
- busy=1 in CLIP, FILL and DONE. cmd_ready=0 whenever busy. Commands are never queued.
- Latency: command accepted in cycle N, first write in N+2 (if not stalled), done in N+2+(number of pixels written)+(number of stall cycles).
- Address: row stride is added incrementally; no multiplier in FILL. map(a)=a when HALF_RES=0 and a>>1 when HALF_RES=1. In HALF_RES mode both pixels of a pair are written to the same address in order (duplicate writes are intentional).
- Outputs are registered. wr_addr and wr_data hold their last value when wr_en=0.

Decomposition:
- Shared package fb_pkg: MAX_SX, MAX_SY, LINE_W, FB_ADDR_W=19, PIX_W=4, the HALF_RES derivation from FRAMEBUFFER_SIZE, and typedef fb_state_t {IDLE, CLIP, FILL, DONE}.
- One natural sub-module: fb_rect_clip, the combinational clip/empty/row_base computation registered in CLIP.

Test Plan:
- x0=10,y0=20,w=3,h=2,color=5, HALF_RES=0 -> writes addr 16010,16011,16012,16810,16811,16812, data=5, first write 2 cycles after accept; done pulses 1 cycle after the last write.
- x0=798,y0=479,w=10,h=10 -> clipped to 2 writes: addrs 383998 and 383999; done follows.
- w=0, and separately x0=900 -> zero wr_en cycles; done pulses 2 cycles after accept.
- Rectangle 4x1 at (0,0) with wr_stall high for cycles 2-4 of the fill -> still exactly 4 writes (addrs 0..3, no gaps or duplicates); done delayed by 3 cycles.
- HALF_RES=1, x0=1,y0=1,w=3,h=1 -> writes addrs 400,401,401.
- rst asserted during FILL of a 100x100 rectangle -> next cycle wr_en=0, busy=0, no done; cmd_ready=1 after rst deasserts; a new command then completes normally.
